// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART with baud ticks, oversampling rx, tx, two FIFOs and sticky errors
module uart_core_param_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic [AW:0]  count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    logic [AW:0] count_n;
    assign do_pop = pop && !empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign count_n = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    assign dout = empty ? '0 : mem[rp];
    always_ff @(posedge clk) if (do_push) mem[wp] <= din;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            empty <= 1'b1;
            full <= 1'b0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count_n;
            empty <= count_n == '0;
            full <= count_n == (AW+1)'(DEPTH);
        end
    end
endmodule

module uart_core_param #(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 921_600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 rx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 write_tx_data,
    input  logic                 read_rx_data,
    input  logic                 clear_err,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 tx,
    output logic                 rx_empty,
    output logic                 rx_full,
    output logic                 tx_empty,
    output logic                 tx_full,
    output logic [AW:0]          rx_count,
    output logic [AW:0]          tx_count,
    output logic                 tx_busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);
    localparam int DIV = (CLOCK_RATE + BAUD_RATE * 8) / (BAUD_RATE * 16);
    localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic [TW-1:0] tick_cnt;
    logic tick;
    assign tick = tick_cnt == TW'(DIV - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) tick_cnt <= '0;
        else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

    state_t rx_state, rx_state_n;
    logic rx_s1, rx_sync, rx_prev, rx_par;
    logic [3:0] rx_tcnt, rx_bcnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic rx_mid, rx_done, rx_push, rx_par_bad, rx_start_hit;
    assign rx_mid = tick && rx_tcnt == 4'hf;
    assign rx_start_hit = tick && rx_tcnt == 4'd7;
    assign rx_push = rx_done && rx_sync;
    assign rx_par_bad = PARITY != 0 && rx_par != (PARITY == 2 ? ^rx_shift : ~^rx_shift);
    always_comb begin
        rx_state_n = rx_state;
        rx_done = 1'b0;
        case (rx_state)
            IDLE:  if (enable && rx_prev && !rx_sync) rx_state_n = START;
            START: if (rx_start_hit) rx_state_n = rx_sync ? IDLE : DATA;
            DATA:  if (rx_mid && rx_bcnt == 4'(DATA_BITS - 1)) rx_state_n = PARITY != 0 ? PAR : STOP;
            PAR:   if (rx_mid) rx_state_n = STOP;
            STOP:  if (rx_mid) begin
                       rx_state_n = IDLE;
                       rx_done = 1'b1;
                   end
            default: rx_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {rx_s1, rx_sync, rx_prev} <= 3'b111;
            rx_state <= IDLE;
            rx_tcnt <= '0;
            rx_bcnt <= '0;
            rx_shift <= '0;
            rx_par <= 1'b0;
            parity_err <= 1'b0;
            frame_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            {rx_s1, rx_sync, rx_prev} <= {rx, rx_s1, rx_sync};
            rx_state <= rx_state_n;
            // restart the tick phase at mid start bit so data samples land mid-bit
            if (rx_state == IDLE || (rx_state == START && rx_start_hit)) rx_tcnt <= '0;
            else if (tick) rx_tcnt <= rx_tcnt + 1'b1;
            if (rx_state == IDLE) rx_bcnt <= '0;
            if (rx_state == DATA && rx_mid) begin
                rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                rx_bcnt <= rx_bcnt + 1'b1;
            end
            if (rx_state == PAR && rx_mid) rx_par <= rx_sync;
            parity_err <= (rx_push && rx_par_bad) || (parity_err && !clear_err);
            frame_err <= (rx_done && !rx_sync) || (frame_err && !clear_err);
            overrun_err <= (rx_push && rx_full && !read_rx_data) || (overrun_err && !clear_err);
        end
    end

    uart_core_param_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH), .AW(AW)) rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(read_rx_data), .din(rx_shift),
        .dout(rx_data), .empty(rx_empty), .full(rx_full), .count(rx_count)
    );

    state_t tx_state, tx_state_n;
    logic [3:0] tx_tcnt, tx_bcnt;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n, tx_head;
    logic tx_par, tx_par_n, tx_n, tx_end, tx_pop, tx_next;
    assign tx_end = tick && tx_tcnt == 4'hf;
    assign tx_next = enable && !tx_empty;
    assign tx_busy = tx_state != IDLE;
    always_comb begin
        tx_state_n = tx_state;
        tx_pop = 1'b0;
        case (tx_state)
            IDLE:  if (tx_next) begin
                       tx_pop = 1'b1;
                       tx_state_n = START;
                   end
            START: if (tx_end) tx_state_n = DATA;
            DATA:  if (tx_end && tx_bcnt == 4'(DATA_BITS - 1)) tx_state_n = PARITY != 0 ? PAR : STOP;
            PAR:   if (tx_end) tx_state_n = STOP;
            // chain straight into the next start bit so queued words leave without a gap
            STOP:  if (tx_end && tx_bcnt == 4'(STOP_BITS - 1)) begin
                       tx_pop = tx_next;
                       tx_state_n = tx_next ? START : IDLE;
                   end
            default: tx_state_n = IDLE;
        endcase
        tx_shift_n = tx_pop ? tx_head : (tx_state == DATA && tx_end) ? tx_shift >> 1 : tx_shift;
        tx_par_n = tx_pop ? (PARITY == 2 ? ^tx_head : ~^tx_head) : tx_par;
        tx_n = tx_state_n == START ? 1'b0 : tx_state_n == DATA ? tx_shift_n[0] : tx_state_n == PAR ? tx_par_n : 1'b1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_tcnt <= '0;
            tx_bcnt <= '0;
            tx_shift <= '0;
            tx_par <= 1'b0;
            tx <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_shift <= tx_shift_n;
            tx_par <= tx_par_n;
            tx <= tx_n;
            if (tx_state == IDLE) tx_tcnt <= '0;
            else if (tick) tx_tcnt <= tx_tcnt + 1'b1;
            if (tx_state_n != tx_state) tx_bcnt <= '0;
            else if (tx_end) tx_bcnt <= tx_bcnt + 1'b1;
        end
    end

    uart_core_param_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH), .AW(AW)) tx_fifo (
        .clk(clk), .reset(reset), .push(write_tx_data), .pop(tx_pop), .din(tx_data),
        .dout(tx_head), .empty(tx_empty), .full(tx_full), .count(tx_count)
    );
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: directed bench for an 8N1 default instance and a 7E2 fast-baud instance
module tb_uart_core_param;
    localparam int DIV_A = 7;
    localparam int BIT_A = 16 * DIV_A;
    localparam int DIV_B = 2;
    localparam int BIT_B = 16 * DIV_B;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;
    always #5 clk = ~clk;

    logic loop_a = 1'b0, rxd_a = 1'b1, write_a = 1'b0, read_a = 1'b0, clr_a = 1'b0;
    logic [7:0] txd_a = '0;
    logic [7:0] rx_data_a;
    logic tx_a, rx_a, rx_empty_a, rx_full_a, tx_empty_a, tx_full_a, tx_busy_a, perr_a, ferr_a, oerr_a;
    logic [4:0] rx_count_a, tx_count_a;
    assign rx_a = loop_a ? tx_a : rxd_a;

    logic rxd_b = 1'b1, write_b = 1'b0, read_b = 1'b0, clr_b = 1'b0;
    logic [6:0] txd_b = '0;
    logic [6:0] rx_data_b;
    logic tx_b, rx_empty_b, rx_full_b, tx_empty_b, tx_full_b, tx_busy_b, perr_b, ferr_b, oerr_b;
    logic [4:0] rx_count_b, tx_count_b;

    uart_core_param dut_a (
        .clk(clk), .reset(reset), .enable(enable), .rx(rx_a), .tx_data(txd_a),
        .write_tx_data(write_a), .read_rx_data(read_a), .clear_err(clr_a), .rx_data(rx_data_a),
        .tx(tx_a), .rx_empty(rx_empty_a), .rx_full(rx_full_a), .tx_empty(tx_empty_a), .tx_full(tx_full_a),
        .rx_count(rx_count_a), .tx_count(tx_count_a), .tx_busy(tx_busy_a),
        .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(oerr_a)
    );

    uart_core_param #(
        .CLOCK_RATE(32_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .rx(rxd_b), .tx_data(txd_b),
        .write_tx_data(write_b), .read_rx_data(read_b), .clear_err(clr_b), .rx_data(rx_data_b),
        .tx(tx_b), .rx_empty(rx_empty_b), .rx_full(rx_full_b), .tx_empty(tx_empty_b), .tx_full(tx_full_b),
        .rx_count(rx_count_b), .tx_count(tx_count_b), .tx_busy(tx_busy_b),
        .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(oerr_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int c, s, pos, prev;
    logic [7:0] v;
    logic [6:0] w, w_exp;
    logic tr [6000];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        txd_a = d;
        write_a = 1'b1;
        @(negedge clk);
        write_a = 1'b0;
    endtask

    task automatic pop_a();
        read_a = 1'b1;
        @(negedge clk);
        read_a = 1'b0;
    endtask

    task automatic wait_rx_a(input string tag);
        int n = 0;
        while (rx_empty_a && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, rx_empty_a, 0);
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop);
        rxd_a = 1'b0;
        repeat (BIT_A) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rxd_a = d[k];
            repeat (BIT_A) @(negedge clk);
        end
        rxd_a = stop;
        repeat (BIT_A) @(negedge clk);
        rxd_a = 1'b1;
        repeat (BIT_A) @(negedge clk);
    endtask

    task automatic send_b(input logic [6:0] d, input logic p);
        rxd_b = 1'b0;
        repeat (BIT_B) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            rxd_b = d[k];
            repeat (BIT_B) @(negedge clk);
        end
        rxd_b = p;
        repeat (BIT_B) @(negedge clk);
        rxd_b = 1'b1;
        repeat (3 * BIT_B) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_busy", tx_busy_a, 0);
        check("rst_flags", {rx_empty_a, rx_full_a, tx_empty_a, tx_full_a}, 4'b1010);
        check("rst_counts", {rx_count_a, tx_count_a}, 0);
        check("rst_rx_data", rx_data_a, 0);
        check("rst_err", {perr_a, ferr_a, oerr_a}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        pop_a();
        check("pop_empty", {rx_empty_a, rx_count_a}, {1'b1, 5'd0});

        // 8N1 transmit of 0xA5 with loopback into the receiver
        loop_a = 1'b1;
        push_a(8'hA5);
        c = 0;
        while (tx_a && c < 20) begin @(negedge clk); c++; end
        check("t1_start", tx_a, 0);
        check("t1_busy", tx_busy_a, 1);
        c = 0;
        while (!tx_a && c < 200) begin @(negedge clk); c++; end
        check("t1_start_len", c >= BIT_A - DIV_A + 1 && c <= BIT_A, 1);
        c = 0;
        while (tx_a && c < 300) begin @(negedge clk); c++; end
        check("t1_bit_len", c, BIT_A);
        v = '0;
        v[0] = c != 0;
        repeat (BIT_A / 2) @(negedge clk);
        v[1] = tx_a;
        for (int k = 2; k < 8; k++) begin
            repeat (BIT_A) @(negedge clk);
            v[k] = tx_a;
        end
        check("t1_tx_data", v, 8'hA5);
        repeat (BIT_A) @(negedge clk);
        check("t1_stop", tx_a, 1);
        wait_rx_a("t1_rx_timeout");
        check("t1_rx_data", rx_data_a, 8'hA5);
        check("t1_rx_count", rx_count_a, 1);
        pop_a();
        check("t1_rx_drained", {rx_empty_a, rx_count_a}, {1'b1, 5'd0});
        repeat (BIT_A) @(negedge clk);
        check("t1_idle", {tx_busy_a, tx_empty_a, tx_a}, 3'b011);
        loop_a = 1'b0;

        // bad stop bit, then an idle-line glitch, then a clean frame
        send_a(8'h3C, 1'b0);
        check("t3_frame_err", ferr_a, 1);
        check("t3_count", {rx_empty_a, rx_count_a}, {1'b1, 5'd0});
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("t3_clear", ferr_a, 0);
        rxd_a = 1'b0;
        repeat (3) @(negedge clk);
        rxd_a = 1'b1;
        repeat (2 * BIT_A) @(negedge clk);
        check("t3_glitch", {rx_empty_a, rx_count_a, perr_a, ferr_a, oerr_a}, {1'b1, 5'd0, 3'b000});
        send_a(8'h96, 1'b1);
        check("t3_recover", rx_data_a, 8'h96);
        pop_a();

        // 7E2: wrong parity still delivers the word, then a correct one
        send_b(7'h55, 1'b1);
        check("t2_count", rx_count_b, 1);
        check("t2_data", rx_data_b, 7'h55);
        check("t2_perr", {perr_b, ferr_b}, 2'b10);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        check("t2_clear", perr_b, 0);
        read_b = 1'b1;
        @(negedge clk);
        read_b = 1'b0;
        send_b(7'h2A, 1'b1);
        check("t2_good", {perr_b, rx_data_b}, {1'b0, 7'h2A});
        read_b = 1'b1;
        @(negedge clk);
        read_b = 1'b0;

        // rx overrun: 17 frames, no reads
        for (int i = 0; i < 17; i++) begin
            w = 7'(16 + i);
            if (i == 16) begin
                check("t4_full16", {rx_full_b, rx_count_b, oerr_b}, {1'b1, 5'd16, 1'b0});
            end
            send_b(w, ^w);
        end
        check("t4_overrun", {rx_full_b, rx_count_b, oerr_b}, {1'b1, 5'd16, 1'b1});
        for (int i = 0; i < 16; i++) begin
            check("t4_drain", rx_data_b, 7'(16 + i));
            read_b = 1'b1;
            @(negedge clk);
            read_b = 1'b0;
        end
        check("t4_empty", {rx_empty_b, rx_count_b}, {1'b1, 5'd0});
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;

        // tx FIFO overflow and back-to-back 7E2 transmission
        enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            txd_b = 7'(64 + i);
            write_b = 1'b1;
            @(negedge clk);
        end
        write_b = 1'b0;
        @(negedge clk);
        check("t5_full", {tx_full_b, tx_count_b, tx_busy_b}, {1'b1, 5'd16, 1'b0});
        enable = 1'b1;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            tr[k] = tx_b;
        end
        pos = 0;
        prev = 0;
        for (int f = 0; f < 16; f++) begin
            s = -1;
            for (int k = pos; k < 5600 && s < 0; k++) if (!tr[k]) s = k;
            check("t5_found", s >= 0, 1);
            if (s < 0) break;
            for (int k = 0; k < 7; k++) w[k] = tr[s + BIT_B / 2 + BIT_B * (k + 1)];
            w_exp = 7'(64 + f);
            check("t5_word", w, w_exp);
            check("t5_parity", tr[s + BIT_B / 2 + BIT_B * 8], ^w_exp);
            check("t5_stops", {tr[s + BIT_B / 2 + BIT_B * 9], tr[s + BIT_B / 2 + BIT_B * 10]}, 2'b11);
            if (f >= 2) check("t5_spacing", s - prev, 11 * BIT_B);
            prev = s;
            pos = s + 10 * BIT_B + BIT_B / 2;
        end
        s = 0;
        for (int k = pos; k < 6000; k++) if (!tr[k]) s = 1;
        check("t5_no_17th", s, 0);
        check("t5_done", {tx_busy_b, tx_empty_b, tx_count_b}, {1'b0, 1'b1, 5'd0});

        // async reset in the middle of a frame
        loop_a = 1'b1;
        push_a(8'h5A);
        push_a(8'h3C);
        c = 0;
        while (tx_a && c < 20) begin @(negedge clk); c++; end
        check("t6_start", tx_a, 0);
        repeat (300) @(negedge clk);
        check("t6_mid", {tx_busy_a, tx_empty_a}, 2'b10);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_tx", tx_a, 1);
        check("t6_rst_busy", tx_busy_a, 0);
        check("t6_rst_empty", {tx_empty_a, tx_count_a}, {1'b1, 5'd0});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_a(8'hC3);
        wait_rx_a("t6_rx_timeout");
        check("t6_rx_data", rx_data_a, 8'hC3);
        repeat (BIT_A) @(negedge clk);
        check("t6_rx_count", rx_count_a, 1);
        check("t6_idle", {tx_busy_a, tx_empty_a}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
